life_row_engine: RTL and testbench



---
 rtl/life_row_engine.sv | 155 +++++++++++++++
 tb/tb_life_row_engine.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_row_engine.sv
// One row of WIDTH Life cells with configurable birth/survive masks, optional decay states and wrap/zero edges.
// Optional `population` output is enabled by defining LIFE_POPCOUNT_EN.
module life_row_engine #(
  parameter int unsigned WIDTH        = 16,
  parameter logic [8:0]  BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0]  SURVIVE_MASK = 9'b000001100,
  parameter int unsigned DECAY_STATES = 0,
  parameter int unsigned WRAP         = 1,
  parameter int unsigned GEN_W        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enb,
  input  logic                     load,
  input  logic [WIDTH-1:0]         load_row,
  input  logic                     step,
  input  logic [WIDTH-1:0]         north,
  input  logic [WIDTH-1:0]         south,
  output logic [WIDTH-1:0]         alive,
  output logic                     busy,
  output logic                     done,
  output logic                     changed,
  output logic [GEN_W-1:0]         gen_count
`ifdef LIFE_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] population
`endif
);

  localparam int unsigned SW = $clog2(DECAY_STATES + 2);
  localparam logic [15:0] BM = 16'(BIRTH_MASK);
  localparam logic [15:0] SM = 16'(SURVIVE_MASK);
  localparam logic [SW-1:0] ST_ALIVE  = SW'(1);
  localparam logic [SW-1:0] DIE_STATE = (DECAY_STATES > 0) ? SW'(2) : '0;
  localparam logic [SW-1:0] LAST      = SW'(DECAY_STATES + 1);

  typedef enum logic [1:0] {IDLE, COUNT, UPDATE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]         snap_n, snap_s, snap_a;
  logic [WIDTH+1:0]         ext_n, ext_s, ext_a;
  logic [WIDTH-1:0][3:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0][SW-1:0] cell_q, cell_d, cell_ld;
  logic [WIDTH-1:0]         alive_d;

  // Extended vectors put the left neighbour of cell i at bit i and the right one at bit i+2.
  generate
    if (WRAP != 0) begin : g_wrap
      assign ext_n = {snap_n[0], snap_n, snap_n[WIDTH-1]};
      assign ext_s = {snap_s[0], snap_s, snap_s[WIDTH-1]};
      assign ext_a = {snap_a[0], snap_a, snap_a[WIDTH-1]};
    end else begin : g_pad
      assign ext_n = {1'b0, snap_n, 1'b0};
      assign ext_s = {1'b0, snap_s, 1'b0};
      assign ext_a = {1'b0, snap_a, 1'b0};
    end
  endgenerate

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_cell
      assign cnt_d[g] = 4'(ext_n[g]) + 4'(ext_n[g+1]) + 4'(ext_n[g+2])
                      + 4'(ext_a[g]) + 4'(ext_a[g+2])
                      + 4'(ext_s[g]) + 4'(ext_s[g+1]) + 4'(ext_s[g+2]);

      assign cell_d[g] = (cell_q[g] == '0)       ? (BM[cnt_q[g]] ? ST_ALIVE : '0) :
                         (cell_q[g] == ST_ALIVE) ? (SM[cnt_q[g]] ? ST_ALIVE : DIE_STATE) :
                         (cell_q[g] == LAST)     ? '0 : (cell_q[g] + ST_ALIVE);

      assign alive_d[g] = (cell_d[g] == ST_ALIVE);
      assign cell_ld[g] = SW'(load_row[g]);
    end
  endgenerate

`ifdef LIFE_POPCOUNT_EN
  localparam int unsigned PW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] pop_src;
  logic [PW-1:0]    pop_d;

  always_comb begin
    pop_src = (state_q == UPDATE) ? alive_d : load_row;
    pop_d   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop_d = pop_d + PW'(pop_src[i]);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!load && step && enb) state_d = COUNT;
      COUNT:   state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cell_q    <= '0;
      alive     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      changed   <= 1'b0;
      gen_count <= '0;
      snap_n    <= '0;
      snap_s    <= '0;
      snap_a    <= '0;
      cnt_q     <= '0;
`ifdef LIFE_POPCOUNT_EN
      population <= '0;
`endif
    end else begin
      busy <= (state_d != IDLE);
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            cell_q    <= cell_ld;
            alive     <= load_row;
            gen_count <= '0;
            changed   <= 1'b0;
`ifdef LIFE_POPCOUNT_EN
            population <= pop_d;
`endif
          end else if (state_d == COUNT) begin
            snap_n <= north;
            snap_s <= south;
            snap_a <= alive;
          end
        end
        COUNT: cnt_q <= cnt_d;
        UPDATE: begin
          cell_q    <= cell_d;
          alive     <= alive_d;
          changed   <= (alive_d != alive);
          gen_count <= gen_count + GEN_W'(1);
          done      <= 1'b1;
`ifdef LIFE_POPCOUNT_EN
          population <= pop_d;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_life_row_engine.sv
// Self-checking bench for life_row_engine: table of row vectors run on WRAP=0/WRAP=1 instances,
// plus latency, collision, enable, decay and mid-step reset sequences.
module tb_life_row_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enb;
  logic       load, step;
  logic [7:0] row, north, south;
  logic [7:0] alive0, alive1;
  logic       busy0, busy1, done0, done1, ch0, ch1;
  logic [15:0] gen0, gen1;

  logic       load2, step2;
  logic [7:0] row2, north2, south2;
  logic [7:0] alive2;
  logic       busy2, done2, ch2;
  logic [1:0] gen2;

`ifdef LIFE_POPCOUNT_EN
  logic [3:0]  pop0, pop1, pop2;
  logic        load3;
  logic [15:0] row3, zero16, alive3, gen3;
  logic        busy3, done3, ch3;
  logic [4:0]  pop3;
`endif

  life_row_engine #(.WIDTH(8), .WRAP(0)) dut0 (
    .clk(clk), .reset(reset), .enb(enb), .load(load), .load_row(row), .step(step),
    .north(north), .south(south), .alive(alive0), .busy(busy0), .done(done0),
    .changed(ch0), .gen_count(gen0)
`ifdef LIFE_POPCOUNT_EN
    , .population(pop0)
`endif
  );

  life_row_engine #(.WIDTH(8), .WRAP(1)) dut1 (
    .clk(clk), .reset(reset), .enb(enb), .load(load), .load_row(row), .step(step),
    .north(north), .south(south), .alive(alive1), .busy(busy1), .done(done1),
    .changed(ch1), .gen_count(gen1)
`ifdef LIFE_POPCOUNT_EN
    , .population(pop1)
`endif
  );

  life_row_engine #(.WIDTH(8), .WRAP(1), .DECAY_STATES(2), .GEN_W(2)) dut2 (
    .clk(clk), .reset(reset), .enb(enb), .load(load2), .load_row(row2), .step(step2),
    .north(north2), .south(south2), .alive(alive2), .busy(busy2), .done(done2),
    .changed(ch2), .gen_count(gen2)
`ifdef LIFE_POPCOUNT_EN
    , .population(pop2)
`endif
  );

`ifdef LIFE_POPCOUNT_EN
  life_row_engine #(.WIDTH(16)) dut3 (
    .clk(clk), .reset(reset), .enb(enb), .load(load3), .load_row(row3), .step(1'b0),
    .north(zero16), .south(zero16), .alive(alive3), .busy(busy3), .done(done3),
    .changed(ch3), .gen_count(gen3), .population(pop3)
  );
`endif

  typedef struct {
    logic [7:0] row, north, south, exp_w0, exp_w1;
    logic       ch_w0, ch_w1;
  } vec_t;

  typedef struct {
    logic [7:0] a0, a1;
    logic       c0, c1;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_done0(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_step(input logic [7:0] r, input logic [7:0] n, input logic [7:0] s);
    @(negedge clk);
    load = 1'b1; row = r; north = n; south = s;
    @(negedge clk);
    load = 1'b0; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic step2_run(input logic [7:0] n, input logic [7:0] exp_alive,
                           input logic [1:0] exp_gen, input string tag);
    bit ok;
    @(negedge clk);
    north2 = n; step2 = 1'b1;
    @(negedge clk);
    step2 = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done2) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, 32'(ok), 32'd1);
    check({tag, "_alive"}, 32'(alive2), 32'(exp_alive));
    check({tag, "_gen"}, 32'(gen2), 32'(exp_gen));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    int   cnt;
    exp_t e;

    vecs[0] = '{8'b00011100, 8'h00, 8'h00, 8'b00001000, 8'b00001000, 1'b1, 1'b1};
    vecs[1] = '{8'b10000001, 8'b00000001, 8'b10000000, 8'b00000000, 8'b10000001, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 8'b00000111, 8'h00, 8'b00000010, 8'b00000010, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'b10000011, 8'h00, 8'b00000000, 8'b00000001, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 8'h00, 8'h00, 8'b01111110, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 8'h00, 8'b10000001, 8'h00, 1'b1, 1'b1};

    reset = 1'b0; enb = 1'b1; load = 1'b0; step = 1'b0;
    row = '0; north = '0; south = '0;
    load2 = 1'b0; step2 = 1'b0; row2 = '0; north2 = '0; south2 = '0;
`ifdef LIFE_POPCOUNT_EN
    load3 = 1'b0; row3 = '0; zero16 = '0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_alive", 32'(alive0), 32'd0);
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_done", 32'(done0), 32'd0);
    check("reset_changed", 32'(ch0), 32'd0);
    check("reset_gen", 32'(gen0), 32'd0);

    // Table vectors: expected results queued at stimulus, compared on done.
    for (int i = 0; i < 7; i++) begin
      load_step(vecs[i].row, vecs[i].north, vecs[i].south);
      sb.push_back('{vecs[i].exp_w0, vecs[i].exp_w1, vecs[i].ch_w0, vecs[i].ch_w1});
      wait_done0(ok);
      e = sb.pop_front();
      check($sformatf("vec%0d_done", i), 32'(ok), 32'd1);
      check($sformatf("vec%0d_done_wrap", i), 32'(done1), 32'd1);
      check($sformatf("vec%0d_alive_pad", i), 32'(alive0), 32'(e.a0));
      check($sformatf("vec%0d_alive_wrap", i), 32'(alive1), 32'(e.a1));
      check($sformatf("vec%0d_changed_pad", i), 32'(ch0), 32'(e.c0));
      check($sformatf("vec%0d_changed_wrap", i), 32'(ch1), 32'(e.c1));
      check($sformatf("vec%0d_gen", i), 32'(gen0), 32'd1);
    end

    // Latency and back-to-back acceptance on the done cycle.
    load_step(8'b00011100, 8'h00, 8'h00);
    check("lat_busy_t0", 32'(busy0), 32'd1);
    check("lat_done_t0", 32'(done0), 32'd0);
    check("lat_alive_t0", 32'(alive0), 32'b00011100);
    @(negedge clk);
    check("lat_busy_t1", 32'(busy0), 32'd1);
    check("lat_done_t1", 32'(done0), 32'd0);
    @(negedge clk);
    check("lat_busy_t2", 32'(busy0), 32'd0);
    check("lat_done_t2", 32'(done0), 32'd1);
    check("lat_alive_t2", 32'(alive0), 32'b00001000);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("b2b_done_low", 32'(done0), 32'd0);
    check("b2b_busy", 32'(busy0), 32'd1);
    repeat (2) @(negedge clk);
    check("b2b_done", 32'(done0), 32'd1);
    check("b2b_alive", 32'(alive0), 32'd0);
    check("b2b_gen", 32'(gen0), 32'd2);
    check("b2b_changed", 32'(ch0), 32'd1);

    // Step with enb low is ignored.
    @(negedge clk);
    enb = 1'b0; step = 1'b1;
    @(negedge clk);
    step = 1'b0; enb = 1'b1;
    check("enb_busy", 32'(busy0), 32'd0);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done0) cnt++;
    end
    check("enb_no_done", 32'(cnt), 32'd0);
    check("enb_gen", 32'(gen0), 32'd2);

    // Load and step together: load wins, step dropped.
    @(negedge clk);
    load = 1'b1; step = 1'b1; row = 8'b00011100; north = '0; south = '0;
    @(negedge clk);
    load = 1'b0; step = 1'b0;
    check("coll_busy", 32'(busy0), 32'd0);
    check("coll_alive", 32'(alive0), 32'b00011100);
    check("coll_gen", 32'(gen0), 32'd0);
    check("coll_changed", 32'(ch0), 32'd0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done0) cnt++;
    end
    check("coll_no_done", 32'(cnt), 32'd0);

    // Load/step held high while busy are ignored.
    step = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done0) cnt++;
      if (k == 0) begin
        step = 1'b1; load = 1'b1; row = 8'hFF;
      end
      if (k == 2) begin
        step = 1'b0; load = 1'b0;
      end
    end
    check("busy_one_done", 32'(cnt), 32'd1);
    check("busy_alive", 32'(alive0), 32'b00001000);
    check("busy_gen", 32'(gen0), 32'd1);
`ifdef LIFE_POPCOUNT_EN
    check("pop_row", 32'(pop0), 32'd1);
`endif

    // Decay: 1 -> 2 -> 3 -> 0 -> 0, dying cells neither reborn nor counted.
    @(negedge clk);
    load2 = 1'b1; row2 = 8'b00000001;
    @(negedge clk);
    load2 = 1'b0;
    check("decay_load", 32'(alive2), 32'd1);
    step2_run(8'h00,       8'h00,       2'd1, "decay1");
    step2_run(8'b10000011, 8'h00,       2'd2, "decay2");
    step2_run(8'b10000011, 8'h00,       2'd3, "decay3");
    step2_run(8'h00,       8'h00,       2'd0, "decay4_genwrap");
    step2_run(8'b10000011, 8'b00000001, 2'd1, "decay5_reborn");

`ifdef LIFE_POPCOUNT_EN
    @(negedge clk);
    load3 = 1'b1; row3 = 16'hF0F0;
    @(negedge clk);
    load3 = 1'b0;
    check("pop16_load", 32'(pop3), 32'd8);
`endif

    // Reset for one edge while in COUNT.
    load_step(8'b00011100, 8'h00, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_reset_alive", 32'(alive0), 32'd0);
    check("mid_reset_busy", 32'(busy0), 32'd0);
    check("mid_reset_done", 32'(done0), 32'd0);
    check("mid_reset_gen", 32'(gen0), 32'd0);
`ifdef LIFE_POPCOUNT_EN
    check("mid_reset_pop16", 32'(pop3), 32'd0);
`endif
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done0) cnt++;
    end
    check("mid_reset_no_done", 32'(cnt), 32'd0);
    load_step(8'b00011100, 8'h00, 8'h00);
    wait_done0(ok);
    check("post_reset_done", 32'(ok), 32'd1);
    check("post_reset_alive", 32'(alive0), 32'b00001000);
    check("post_reset_gen", 32'(gen0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
